// File: rtl/silly_dec_pkg.sv
// Shared types and constants for the divided-clock mask decoder.
package silly_dec_pkg;

  localparam int unsigned NUM_CH          = 8;
  localparam int unsigned DEF_WINDOW_LOG2 = 8;
  localparam int unsigned DEF_TOL         = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_REPORT  = 2'd2
  } state_e;

  // Nominal edge count of channel i over a 2^window_log2 cycle window.
  function automatic int unsigned expected_edges(input int unsigned i,
                                                 input int unsigned window_log2);
    return (32'd1 << window_log2) >> i;
  endfunction

endpackage

// File: rtl/silly_dec_chan.sv
// One channel: edge detect, saturating edge counter, mask and rate-error compare.
module silly_dec_chan
  import silly_dec_pkg::*;
#(
  parameter int unsigned CH_IDX      = 0,
  parameter int unsigned WINDOW_LOG2 = DEF_WINDOW_LOG2,
  parameter int unsigned TOL         = DEF_TOL
) (
  input  logic clk,
  input  logic reset,
  input  logic samp_i,
  input  logic prev_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic mask_c_o,
  output logic rate_err_c_o
);

  localparam int unsigned CW       = WINDOW_LOG2 + 1;
  localparam int unsigned CMPW     = WINDOW_LOG2 + 2;
  localparam int unsigned EXP_EDGE = expected_edges(CH_IDX, WINDOW_LOG2);
  localparam logic [CW-1:0]   CNT_MAX = '1;
  localparam logic [CMPW-1:0] EXP_B   = CMPW'(EXP_EDGE);
  localparam logic [CMPW-1:0] TOL_B   = CMPW'(TOL);

  logic          edge_det;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CMPW-1:0] cnt_ext;

  assign edge_det = samp_i ^ prev_i;

  // Next count: clear on start, add one per edge while measuring, saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && edge_det && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Edge count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt < E-TOL is written as cnt+TOL < E, which also covers a lower bound clamped at 0.
  assign cnt_ext      = CMPW'(cnt_q);
  assign mask_c_o     = (cnt_q != '0);
  assign rate_err_c_o = (cnt_q != '0) &&
                        (((cnt_ext + TOL_B) < EXP_B) || (cnt_ext > (EXP_B + TOL_B)));

endmodule

// File: rtl/silly_mask_decoder.sv
// Measures 8 divided-clock lines over a 2^WINDOW_LOG2 window and reports
// which channels toggled and which toggled at the wrong rate.
// Optional macro SILLY_DEC_SYNC_EN inserts a 2-flop synchronizer ahead of samp.
module silly_mask_decoder
  import silly_dec_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2 = DEF_WINDOW_LOG2,
  parameter int unsigned TOL         = DEF_TOL
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   sig_in,
  input  logic                start,
  output logic                busy,
  output logic                valid,
  output logic [NUM_CH-1:0]   mask_out,
  output logic [NUM_CH-1:0]   rate_err
);

  state_e                   state_q, state_d;
  logic [WINDOW_LOG2-1:0]   win_q, win_d;
  logic                     win_last;
  logic                     clear_c, count_en_c, load_c;
  logic [NUM_CH-1:0]        samp_src, samp_q, prev_q;
  logic [NUM_CH-1:0]        chan_mask_c, chan_rerr_c;
  logic                     busy_q, valid_q;
  logic [NUM_CH-1:0]        mask_q, rerr_q;

`ifdef SILLY_DEC_SYNC_EN
  logic [NUM_CH-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for lines not already on clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
    end
  end

  assign samp_src = sync2_q;
`else
  assign samp_src = sig_in;
`endif

  // Sample and previous-sample registers, running in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_q <= '0;
      prev_q <= '0;
    end else begin
      samp_q <= samp_src;
      prev_q <= samp_q;
    end
  end

  assign win_last = (win_q == '1);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_MEASURE;
      ST_MEASURE: if (win_last) state_d = ST_REPORT;
      ST_REPORT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: counter control, window counter next value, result load.
  always_comb begin
    clear_c    = 1'b0;
    count_en_c = 1'b0;
    load_c     = 1'b0;
    win_d      = win_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear_c = 1'b1;
          win_d   = '0;
        end
      end
      ST_MEASURE: begin
        count_en_c = 1'b1;
        win_d      = win_q + WINDOW_LOG2'(1);
      end
      ST_REPORT: begin
        load_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Per-channel counters and compares.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    silly_dec_chan #(
      .CH_IDX      (g),
      .WINDOW_LOG2 (WINDOW_LOG2),
      .TOL         (TOL)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .samp_i       (samp_q[g]),
      .prev_i       (prev_q[g]),
      .clear_i      (clear_c),
      .count_en_i   (count_en_c),
      .mask_c_o     (chan_mask_c[g]),
      .rate_err_c_o (chan_rerr_c[g])
    );
  end

  // Window counter and registered outputs; results hold until the next report.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      mask_q  <= '0;
      rerr_q  <= '0;
    end else begin
      win_q   <= win_d;
      busy_q  <= (state_d != ST_IDLE);
      valid_q <= load_c;
      if (load_c) begin
        mask_q <= chan_mask_c;
        rerr_q <= chan_rerr_c;
      end
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign mask_out = mask_q;
  assign rate_err = rerr_q;

endmodule

// File: tb/tb_silly_mask_decoder.sv
// Randomized bench for silly_mask_decoder with a transition-counting reference model.
module tb_silly_mask_decoder;

  localparam int W   = 256;
  localparam int TOL = 1;
`ifdef SILLY_DEC_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  localparam int HMAX = 8192;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] sig_in;
  logic       busy, valid;
  logic [7:0] mask_out, rate_err;

  always #5 clk = ~clk;

  silly_mask_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (sig_in),
    .start    (start),
    .busy     (busy),
    .valid    (valid),
    .mask_out (mask_out),
    .rate_err (rate_err)
  );

  int         cyc = 0;
  logic [7:0] hist [0:HMAX-1];
  int         n_chk = 0, n_pass = 0;

  // stimulus generator knobs
  logic [7:0]  gen_mask, fc, rnd_lines;
  bit          ch3_fast, ch5_hi, rnd_mode;
  int unsigned rnd_rate;

  // reference model state
  bit         m_active;
  int         m_s;
  logic       m_busy, m_valid;
  logic [7:0] m_mask, m_rerr;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
  endtask

  // Count transitions each line made across the W sample pairs seen in the window.
  task automatic model_results(input int s, output logic [7:0] mk, output logic [7:0] re);
    for (int ch = 0; ch < 8; ch++) begin
      int c, e, lo;
      c = 0;
      for (int k = s + 1; k <= s + W; k++)
        if (hist[k-1-D][ch] != hist[k-2-D][ch]) c++;
      e  = W >> ch;
      lo = (e - TOL < 0) ? 0 : e - TOL;
      mk[ch] = (c != 0);
      re[ch] = (c != 0) && (c < lo || c > e + TOL);
    end
  endtask

  // Model step on the inputs of the ending cycle, then drive the next cycle's lines.
  always @(posedge clk) begin
    logic [7:0] v;
    if (reset) begin
      m_active = 1'b0;
      m_valid  = 1'b0;
      m_mask   = 8'h00;
      m_rerr   = 8'h00;
    end else begin
      m_valid = 1'b0;
      if (m_active && cyc == m_s + W + 1) begin
        model_results(m_s, m_mask, m_rerr);
        m_valid  = 1'b1;
        m_active = 1'b0;
      end else if (!m_active && start) begin
        m_active = 1'b1;
        m_s      = cyc;
      end
    end
    m_busy = m_active;
    cyc++;
    if (cyc >= HMAX) begin
      $display("FAIL cycle_budget cyc=%0d", cyc);
      $fatal(1);
    end
    #1;
    fc = fc + 8'd1;
    for (int i = 0; i < 8; i++)
      if ($urandom_range(rnd_rate - 1, 0) == 0) rnd_lines[i] = ~rnd_lines[i];
    v = rnd_mode ? rnd_lines : (fc & gen_mask);
    if (ch3_fast) v[3] = fc[2];
    if (ch5_hi)   v[5] = 1'b1;
    sig_in    = v;
    hist[cyc] = v;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy",     8'(busy),  8'(m_busy));
      chk("valid",    8'(valid), 8'(m_valid));
      chk("mask_out", mask_out,  m_mask);
      chk("rate_err", rate_err,  m_rerr);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_gen(input logic [7:0] m, input bit c3, input bit c5, input bit rm);
    gen_mask = m;
    ch3_fast = c3;
    ch5_hi   = c5;
    rnd_mode = rm;
    step(8);
  endtask

  // Pulse start, wait (bounded) for valid, check latency and optionally literal results.
  task automatic measure(input logic [7:0] em, input logic [7:0] er, input bit lit);
    int s, got;
    start = 1'b1;
    s     = cyc;
    step(1);
    start = 1'b0;
    got   = -1;
    for (int i = 0; i < 400 && got < 0; i++) begin
      if (valid === 1'b1) got = cyc;
      else step(1);
    end
    chk_int("latency", got - s, W + 2);
    if (lit) begin
      chk("lit_mask", mask_out, em);
      chk("lit_rerr", rate_err, er);
    end
    step(1);
  endtask

  initial begin
    int s, nv;
    for (int i = 0; i < HMAX; i++) hist[i] = 8'h00;
    reset = 1'b1; start = 1'b0; sig_in = 8'h00;
    gen_mask = 8'h00; fc = 8'h00; rnd_lines = 8'h00; rnd_rate = 4;
    ch3_fast = 1'b0; ch5_hi = 1'b0; rnd_mode = 1'b0;
    m_active = 1'b0; m_s = 0; m_busy = 1'b0; m_valid = 1'b0;
    m_mask = 8'h00; m_rerr = 8'h00;

    step(4);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_mask", mask_out, 8'h00);
    chk("rst_rerr", rate_err, 8'h00);
    reset = 1'b0;
    step(6);

    set_gen(8'hA5, 0, 0, 0);
    measure(8'hA5, 8'h00, 1);

    set_gen(8'h00, 0, 0, 0);
    measure(8'h00, 8'h00, 1);

    set_gen(8'hFF, 1, 0, 0);
    measure(8'hFF, 8'h08, 1);

    set_gen(8'h0F, 0, 1, 0);
    measure(8'h0F, 8'h00, 1);

    // Extra starts at MEASURE cycle 50 and in REPORT must be ignored.
    set_gen(8'h3C, 0, 0, 0);
    start = 1'b1; s = cyc; nv = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      start = (cyc == s + 50) || (cyc == s + 257);
      if (valid === 1'b1) nv++;
    end
    start = 1'b0;
    chk_int("one_valid", nv, 1);
    chk("idle_after", 8'(busy), 8'h00);
    chk("lit_mask_3c", mask_out, 8'h3C);

    // Reset at MEASURE cycle 100 aborts with no valid, then a fresh run completes.
    set_gen(8'hA5, 0, 0, 0);
    measure(8'hA5, 8'h00, 1);
    start = 1'b1; s = cyc;
    step(1);
    start = 1'b0;
    while (cyc < s + 100) step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("abort_busy", 8'(busy), 8'h00);
    chk("abort_mask", mask_out, 8'h00);
    chk("abort_rerr", rate_err, 8'h00);
    nv = 0;
    for (int i = 0; i < 300; i++) begin
      if (valid === 1'b1) nv++;
      step(1);
    end
    chk_int("no_valid", nv, 0);
    measure(8'hA5, 8'h00, 1);

    // Randomized lines and masks, results checked by the model only.
    for (int r = 0; r < 8; r++) begin
      rnd_rate = $urandom_range(8, 1);
      set_gen(8'($urandom), 1'($urandom), 1'($urandom), (r % 2) == 0);
      step($urandom_range(20, 0));
      measure(8'h00, 8'h00, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/silly_mask_decoder.md
Name: silly_mask_decoder

Overview:
- Receive-side block for the gated divided-clock output bus: observes 8 lines, each carrying either a divided clock or a constant.
- Channel i nominally toggles every 2^i clk cycles (channel 0 = clk/2, channel 7 = clk/256).
- On request, measures every line over a fixed window and reports which channels were active (the recovered mask) and which toggled at the wrong rate.
- Sits on the loopback/test side of the design, on the same clk.

Parameters:
- WINDOW_LOG2, 8, measurement window length is W = 2^WINDOW_LOG2 cycles; legal range 7..12.
- TOL, 1, allowed |edge count − expected| before a channel is flagged as a rate error.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sig_in  input  8  observed signal lines; bit i is channel i
- start  input  1  single-cycle request to begin a measurement
- busy  output  1  high while a measurement is in progress
- valid  output  1  one-cycle pulse when results update
- mask_out  output  8  recovered mask: bit i = channel i saw ≥1 edge
- rate_err  output  8  bit i = channel i active but edge count outside expected ± TOL

Behaviour:
- Reset: clk and reset are decided as stated in Ports (synchronous, active-high). Reset clears state to IDLE and drives busy=0, valid=0, mask_out=0, rate_err=0. Counters, window counter and sample registers are also cleared. Reset mid-measurement aborts it with no valid pulse.
- Sampling: sig_in is registered (samp); prev holds the previous samp and updates every cycle in all states. edge[i] = samp[i] ^ prev[i].
- State machine:
  - IDLE: busy=0. start=1 → MEASURE; clears all edge counters and the window counter.
  - MEASURE: busy=1. Each cycle, every channel counter adds edge[i]. After exactly W MEASURE cycles → REPORT.
  - REPORT: busy=1 for one cycle. Registers results, then → IDLE.
  - valid is high in the cycle after REPORT, together with the new mask_out and rate_err.
- Latency: start accepted in cycle 0; MEASURE occupies cycles 1..W; REPORT is cycle W+1; valid=1 in cycle W+2.
- Results hold until the next valid or reset.
- start while busy=1 is ignored: not queued, no effect.
- start in the same cycle as the REPORT→IDLE transition is ignored. start is only sampled in IDLE.
- Counters are WINDOW_LOG2+1 bits wide; the maximum count W fits, so there is no overflow. Counters saturate as a safety measure.
- Expected edges for channel i: E_i = W >> i.
- mask_out[i] = (count_i != 0).
- rate_err[i] = (count_i != 0) && (count_i < E_i − TOL || count_i > E_i + TOL). Comparison is unsigned, computed in WINDOW_LOG2+2 bits; a negative lower bound clamps to 0.
- A stuck line (constant 0 or 1) gives mask_out=0 and rate_err=0.
- A line that changes mid-window is reported from whatever edges occurred; there is no special handling.

Optional Feature:
- Macro: SILLY_DEC_SYNC_EN.
- Defined: sig_in passes through a 2-flop synchronizer before samp. This adds 2 cycles of pipeline delay to the sampling path; the window length and valid timing relative to start are unchanged.
- Undefined: single samp register only, for sig_in already synchronous to clk.

Decomposition:
- Package silly_dec_pkg:
  - state typedef (IDLE, MEASURE, REPORT);
  - default WINDOW_LOG2 and TOL constants;
  - function expected_edges(i, window_log2).
- Sub-module silly_dec_chan, instantiated 8 times, contains:
  - the edge detector;
  - the count register (saturating);
  - the mask and rate-error compare for one channel (channel index passed as a parameter).
- The top level holds the FSM, window counter and output registers.

Test Plan (W=256, TOL=1, sig_in[i] = bit i of a free-running 8-bit up-counter, ANDed with a driven mask):
- Mask 0xA5, pulse start → valid at cycle 258 after start; mask_out=0xA5, rate_err=0x00; busy high cycles 1..257.
- Mask 0x00 → mask_out=0x00, rate_err=0x00, valid still pulses once at cycle 258.
- Mask 0xFF, but channel 3 replaced by a line toggling every 4 cycles (64 edges vs E_3=32) → mask_out=0xFF, rate_err=0x08.
- Channel 5 held at 1, others mask 0x0F → mask_out=0x0F, rate_err=0x00.
- start pulsed again at cycles 50 and 257 during a measurement → exactly one valid; next measurement starts only on a start in IDLE.
- reset asserted at cycle 100 of MEASURE → next cycle busy=0, mask_out=0x00, rate_err=0x00; no valid; a fresh start then completes normally.
